sysbus_arbiter: RTL and testbench

Two-port arbiter that shares the single system-bus master interface between two requesters, port 0 (instruction fetch) and port 1 (data access). Each port speaks the same reqcyc/reqack/respcyc/respack protocol as the bus, so a requester cannot tell whether it is attached directly or through the arbiter. Grant is round-robin and is held for one complete transaction, meaning a request plus its full burst. The block sits between the core-side requesters and the top-level bus ports.

---
 rtl/sysbus_arbiter_pkg.sv | 18 +
 rtl/sysbus_arbiter_rr_pick2.sv | 15 +
 rtl/sysbus_arbiter.sv | 163 ++++++++++++++++
 tb/tb_sysbus_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysbus_arbiter_pkg.sv
// Shared types and constants for the two-port system-bus arbiter.
package sysbus_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      RDATA = 2'd2,
      WDATA = 2'd3
   } arb_state_t;

   // Direction bit position inside the request tag, and its encodings
   localparam int   DIR_BIT       = 12;
   localparam logic SYSBUS_READ   = 1'b1;
   localparam logic SYSBUS_WRITE  = 1'b0;

   localparam int   BEATS_DEFAULT = 8;

endpackage

// File: rtl/sysbus_arbiter_rr_pick2.sv
// Combinational two-way round-robin selector: on a tie the port that was not
// served last wins.
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       grant_valid,
   output logic       grant_idx
);

   always_comb begin
      grant_valid = |req;
      grant_idx   = (req == 2'b11) ? ~last : req[1];
   end

endmodule

// File: rtl/sysbus_arbiter.sv
// Shares one system-bus master between an instruction-fetch port (0) and a
// data port (1); a grant covers one request plus its whole burst.
module sysbus_arbiter
   import sysbus_arb_pkg::*;
#(
   parameter int BUS_DATA_WIDTH = 64,
   parameter int BUS_TAG_WIDTH  = 13,
   parameter int BEATS          = BEATS_DEFAULT
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      p0_bus_reqcyc,
   input  logic [BUS_DATA_WIDTH-1:0] p0_bus_req,
   input  logic [BUS_TAG_WIDTH-1:0]  p0_bus_reqtag,
   input  logic                      p0_bus_respack,
   output logic                      p0_bus_reqack,
   output logic                      p0_bus_respcyc,
   output logic [BUS_DATA_WIDTH-1:0] p0_bus_resp,
   output logic [BUS_TAG_WIDTH-1:0]  p0_bus_resptag,
   input  logic                      p1_bus_reqcyc,
   input  logic [BUS_DATA_WIDTH-1:0] p1_bus_req,
   input  logic [BUS_TAG_WIDTH-1:0]  p1_bus_reqtag,
   input  logic                      p1_bus_respack,
   output logic                      p1_bus_reqack,
   output logic                      p1_bus_respcyc,
   output logic [BUS_DATA_WIDTH-1:0] p1_bus_resp,
   output logic [BUS_TAG_WIDTH-1:0]  p1_bus_resptag,
   output logic                      bus_reqcyc,
   output logic [BUS_DATA_WIDTH-1:0] bus_req,
   output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
   output logic                      bus_respack,
   input  logic                      bus_respcyc,
   input  logic                      bus_reqack,
   input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
   input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

   localparam int BEAT_W = $clog2(BEATS) + 1;

   arb_state_t        state_reg, state_next;
   logic              owner_reg, owner_next;
   logic              last_reg, last_next;
   logic [BEAT_W-1:0] beat_reg, beat_next;

   logic [1:0]                p_reqcyc, p_respack, p_reqack, p_respcyc;
   logic [BUS_DATA_WIDTH-1:0] p_req [2];
   logic [BUS_DATA_WIDTH-1:0] p_resp [2];
   logic [BUS_TAG_WIDTH-1:0]  p_reqtag [2];
   logic [BUS_TAG_WIDTH-1:0]  p_resptag [2];

   logic                      grant_valid, grant_idx;
   logic                      own_reqcyc, own_respack;
   logic [BUS_DATA_WIDTH-1:0] own_req;
   logic [BUS_TAG_WIDTH-1:0]  own_reqtag;
   logic                      route_req, route_resp, final_beat;

   assign p_reqcyc   = {p1_bus_reqcyc, p0_bus_reqcyc};
   assign p_respack  = {p1_bus_respack, p0_bus_respack};
   assign p_req[0]    = p0_bus_req;
   assign p_req[1]    = p1_bus_req;
   assign p_reqtag[0] = p0_bus_reqtag;
   assign p_reqtag[1] = p1_bus_reqtag;

   assign p0_bus_reqack  = p_reqack[0];
   assign p1_bus_reqack  = p_reqack[1];
   assign p0_bus_respcyc = p_respcyc[0];
   assign p1_bus_respcyc = p_respcyc[1];
   assign p0_bus_resp    = p_resp[0];
   assign p1_bus_resp    = p_resp[1];
   assign p0_bus_resptag = p_resptag[0];
   assign p1_bus_resptag = p_resptag[1];

   rr_pick2 u_pick (
      .req         (p_reqcyc),
      .last        (last_reg),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   assign own_reqcyc  = p_reqcyc[owner_reg];
   assign own_respack = p_respack[owner_reg];
   assign own_req     = p_req[owner_reg];
   assign own_reqtag  = p_reqtag[owner_reg];
   assign final_beat  = (beat_reg == BEAT_W'(BEATS - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         owner_reg <= 1'b0;
         last_reg  <= 1'b1;
         beat_reg  <= '0;
      end else begin
         state_reg <= state_next;
         owner_reg <= owner_next;
         last_reg  <= last_next;
         beat_reg  <= beat_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      owner_next = owner_reg;
      last_next  = last_reg;
      beat_next  = beat_reg;
      case (state_reg)
         IDLE: begin
            if (grant_valid) begin
               owner_next = grant_idx;
               state_next = REQ;
            end
         end
         REQ: begin
            if (bus_reqcyc && bus_reqack) begin
               beat_next  = '0;
               state_next = (own_reqtag[DIR_BIT] == SYSBUS_READ) ? RDATA : WDATA;
            end
         end
         RDATA: begin
            if (bus_respcyc && bus_respack) begin
               beat_next = beat_reg + 1'b1;
               if (final_beat) begin
                  last_next  = owner_reg;
                  state_next = IDLE;
               end
            end
         end
         WDATA: begin
            if (bus_reqcyc && bus_reqack) begin
               beat_next = beat_reg + 1'b1;
               if (final_beat) begin
                  last_next  = owner_reg;
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Everything below is pure routing from registered state: no per-beat latency
   always_comb begin
      route_req   = (state_reg == REQ) || (state_reg == WDATA);
      route_resp  = (state_reg == RDATA);
      bus_reqcyc  = route_req && own_reqcyc;
      bus_req     = route_req ? own_req : '0;
      bus_reqtag  = route_req ? own_reqtag : '0;
      bus_respack = route_resp && own_respack;
   end

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_port
         logic sel;
         assign sel = (owner_reg == 1'(gi));
         always_comb begin
            p_reqack[gi]  = route_req && sel && bus_reqack;
            p_respcyc[gi] = route_resp && sel && bus_respcyc;
            p_resp[gi]    = (route_resp && sel) ? bus_resp : '0;
            p_resptag[gi] = (route_resp && sel) ? bus_resptag : '0;
         end
      end
   endgenerate

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Randomized bench for sysbus_arbiter: requester and memory models around the
// DUT, scoreboard queues filled at issue time and drained by the monitor.
module tb_sysbus_arbiter;

   localparam int DW = 64;
   localparam int TW = 13;
   localparam int NB = 8;

   typedef struct {logic [DW-1:0] addr; logic [TW-1:0] tag;} rq_t;
   typedef struct {logic [DW-1:0] data; logic [TW-1:0] tag;} rs_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic          preqcyc [2];
   logic [DW-1:0] preq [2];
   logic [TW-1:0] preqtag [2];
   logic          prespack [2];
   logic          o_reqack [2];
   logic          o_respcyc [2];
   logic [DW-1:0] o_resp [2];
   logic [TW-1:0] o_resptag [2];
   logic          bus_reqcyc, bus_respack, bus_respcyc, bus_reqack;
   logic [DW-1:0] bus_req, bus_resp;
   logic [TW-1:0] bus_reqtag, bus_resptag;

   sysbus_arbiter #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .BEATS(NB)) dut (
      .clk(clk), .reset(reset),
      .p0_bus_reqcyc(preqcyc[0]), .p0_bus_req(preq[0]), .p0_bus_reqtag(preqtag[0]),
      .p0_bus_respack(prespack[0]), .p0_bus_reqack(o_reqack[0]), .p0_bus_respcyc(o_respcyc[0]),
      .p0_bus_resp(o_resp[0]), .p0_bus_resptag(o_resptag[0]),
      .p1_bus_reqcyc(preqcyc[1]), .p1_bus_req(preq[1]), .p1_bus_reqtag(preqtag[1]),
      .p1_bus_respack(prespack[1]), .p1_bus_reqack(o_reqack[1]), .p1_bus_respcyc(o_respcyc[1]),
      .p1_bus_resp(o_resp[1]), .p1_bus_resptag(o_resptag[1]),
      .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_respack(bus_respack),
      .bus_respcyc(bus_respcyc), .bus_reqack(bus_reqack), .bus_resp(bus_resp), .bus_resptag(bus_resptag)
   );

   int total = 0;
   int bad = 0;

   // Requester models: 0 idle, 1 request pending, 2 write beats, 3 read beats
   int            pstate [2];
   logic [DW-1:0] paddr [2];
   logic [TW-1:0] ptag [2];
   logic [DW-1:0] pwdata [2][NB];
   int            pwbeat [2];
   int            prbeat [2];
   int            issued [2];
   int            done [2];
   rq_t           req_q [2][$];
   rs_t           resp_q [2][$];
   logic [DW-1:0] wr_q [2][$];

   // Memory model and high-level arbitration expectations
   int            mphase;   // 0 no burst, 1 write burst, 2 read burst
   int            mcur, mbeat, gport, seq;
   logic [DW-1:0] maddr;
   logic [TW-1:0] mtag;
   logic          last_done;
   bit            prev_arb, just_done, post_reset, allow_issue;
   bit [1:0]      prev_pend;
   int            req_pct;

   function automatic logic [DW-1:0] mem_data(logic [DW-1:0] a, int k);
      return (a + 64'(k) * 64'h8) ^ 64'h5A5A_0000_C3C3_0000;
   endfunction

   task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic issue(int p, bit dir);
      seq++;
      paddr[p]  = {32'h0, $urandom} & ~64'h3F;
      ptag[p]   = {dir, 1'(p), 11'(seq)};
      pstate[p] = 1;
      issued[p]++;
      req_q[p].push_back('{paddr[p], ptag[p]});
      for (int k = 0; k < NB; k++) begin
         if (dir) begin
            resp_q[p].push_back('{mem_data(paddr[p], k), ptag[p]});
         end else begin
            pwdata[p][k] = {$urandom, $urandom};
            wr_q[p].push_back(pwdata[p][k]);
         end
      end
   endtask

   task automatic clear_models();
      for (int p = 0; p < 2; p++) begin
         pstate[p] = 0;
         issued[p] = done[p];
         req_q[p].delete();
         resp_q[p].delete();
         wr_q[p].delete();
      end
      mphase = 0; last_done = 1'b1; gport = -1;
      prev_arb = 0; prev_pend = 2'b00; just_done = 0; post_reset = 1;
   endtask

   task automatic drive();
      for (int p = 0; p < 2; p++)
         if (allow_issue && pstate[p] == 0 && $urandom_range(99) < req_pct)
            issue(p, 1'($urandom_range(1)));
      for (int p = 0; p < 2; p++) begin
         preqcyc[p] = 1'b0;
         preq[p]    = {$urandom, $urandom};
         preqtag[p] = 13'($urandom);
         if (pstate[p] == 1) begin
            preqcyc[p] = 1'b1; preq[p] = paddr[p]; preqtag[p] = ptag[p];
         end else if (pstate[p] == 2) begin
            preqcyc[p] = ($urandom_range(3) != 0);
            preq[p] = pwdata[p][pwbeat[p]]; preqtag[p] = ptag[p];
         end
         prespack[p] = ($urandom_range(99) < 70);
      end
      bus_reqack = ($urandom_range(99) < 50);
      if (mphase == 2) begin
         bus_respcyc = ($urandom_range(99) < 60);
         bus_resp    = mem_data(maddr, mbeat);
         bus_resptag = mtag;
      end else begin
         bus_respcyc = ($urandom_range(99) < 15);
         bus_resp    = {$urandom, $urandom};
         bus_resptag = 13'($urandom);
      end
   endtask

   task automatic finish_burst();
      $display("txn port=%0d dir=%s addr=%0h", mcur, mtag[12] ? "RD" : "WR", maddr);
      mphase = 0; last_done = 1'(mcur); done[mcur]++; just_done = 1;
   endtask

   task automatic monitor();
      bit       arb_now;
      bit [1:0] pend_now;
      int       ep, p;
      rq_t      r;
      rs_t      e;
      logic [DW-1:0] w;
      arb_now  = (mphase == 0) && !bus_reqcyc;
      pend_now = {pstate[1] == 1, pstate[0] == 1};
      if (post_reset) begin
         chk("rst_bus_reqcyc", bus_reqcyc, 0);
         chk("rst_bus_req", bus_req, 0);
         chk("rst_bus_respack", bus_respack, 0);
         for (int q = 0; q < 2; q++) begin
            chk("rst_reqack", o_reqack[q], 0);
            chk("rst_respcyc", o_respcyc[q], 0);
            chk("rst_resp", o_resp[q], 0);
         end
         post_reset = 0;
      end
      if (mphase == 0) begin
         if (just_done) chk("idle_gap", bus_reqcyc, 0);
         else if (prev_arb) begin
            if (prev_pend != 2'b00) begin
               ep = (prev_pend == 2'b11) ? (last_done ? 0 : 1) : (prev_pend[1] ? 1 : 0);
               chk("grant_cyc", bus_reqcyc, 1);
               chk("grant_tag", bus_reqtag, req_q[ep][0].tag);
               gport = ep;
            end else chk("idle_hold", bus_reqcyc, 0);
         end
         if (!bus_reqcyc) begin
            chk("idle_bus_req", bus_req, 0);
            chk("idle_bus_reqtag", bus_reqtag, 0);
         end
      end
      just_done = 0;
      for (int q = 0; q < 2; q++) begin
         bit own_rd;
         own_rd = (mphase == 2) && (mcur == q);
         if (mphase == 1) chk("wr_reqack", o_reqack[q], (mcur == q) ? bus_reqack : 1'b0);
         else if (mphase == 2) chk("rd_reqack", o_reqack[q], 0);
         else chk("req_reqack", o_reqack[q], (bus_reqcyc && gport == q) ? bus_reqack : 1'b0);
         chk("respcyc", o_respcyc[q], own_rd ? bus_respcyc : 1'b0);
         chk("resp", o_resp[q], own_rd ? bus_resp : '0);
         chk("resptag", o_resptag[q], own_rd ? bus_resptag : '0);
      end
      chk("bus_respack", bus_respack, (mphase == 2) ? prespack[mcur] : 1'b0);
      if (mphase == 1) chk("wr_bus_reqcyc", bus_reqcyc, preqcyc[mcur]);
      if (mphase == 2) chk("rd_bus_reqcyc", bus_reqcyc, 0);

      // Requester-side handshakes
      for (int q = 0; q < 2; q++) begin
         if (o_respcyc[q] && prespack[q]) begin
            chk("resp_state", pstate[q], 3);
            if (resp_q[q].size() != 0) begin
               e = resp_q[q].pop_front();
               chk("rdata", o_resp[q], e.data);
               chk("rtag", o_resptag[q], e.tag);
            end
            prbeat[q]++;
            if (prbeat[q] == NB) pstate[q] = 0;
         end
         if (o_reqack[q] && preqcyc[q]) begin
            if (pstate[q] == 1) begin
               pstate[q] = ptag[q][12] ? 3 : 2; pwbeat[q] = 0; prbeat[q] = 0;
            end else begin
               chk("wbeat_state", pstate[q], 2);
               pwbeat[q]++;
               if (pwbeat[q] == NB) pstate[q] = 0;
            end
         end
      end

      // Memory-side handshakes
      if (mphase == 0 && bus_reqcyc && bus_reqack) begin
         p = int'(bus_reqtag[11]);
         chk("req_q_nonempty", req_q[p].size() != 0, 1);
         if (req_q[p].size() != 0) begin
            r = req_q[p].pop_front();
            chk("req_addr", bus_req, r.addr);
            chk("req_tag", bus_reqtag, r.tag);
         end
         mcur = p; maddr = bus_req; mtag = bus_reqtag; mbeat = 0;
         mphase = bus_reqtag[12] ? 2 : 1;
      end else if (mphase == 1 && bus_reqcyc && bus_reqack) begin
         w = (wr_q[mcur].size() != 0) ? wr_q[mcur].pop_front() : '0;
         chk("wdata", bus_req, w);
         mbeat++;
         if (mbeat == NB) finish_burst();
      end else if (mphase == 2 && bus_respcyc && bus_respack) begin
         mbeat++;
         if (mbeat == NB) finish_burst();
      end
      prev_arb  = arb_now;
      prev_pend = pend_now;
   endtask

   task automatic cycle();
      @(negedge clk);
      reset = 1'b0;
      drive();
      #1;
      monitor();
   endtask

   task automatic apply_reset(int n);
      @(negedge clk);
      reset = 1'b1;
      clear_models();
      drive();
      repeat (n - 1) @(negedge clk);
   endtask

   function automatic bit busy();
      return (pstate[0] != 0) || (pstate[1] != 0) || (mphase != 0);
   endfunction

   task automatic drain(int maxc);
      int n = 0;
      while (busy() && n < maxc) begin
         cycle();
         n++;
      end
      chk("drain_busy", 64'(busy()), 0);
   endtask

   initial begin
      int n;
      seq = 0; allow_issue = 0; req_pct = 0;
      for (int p = 0; p < 2; p++) begin
         issued[p] = 0; done[p] = 0; pwbeat[p] = 0; prbeat[p] = 0;
      end
      mcur = 0; mbeat = 0; maddr = '0; mtag = '0;
      apply_reset(3);

      // First tie after reset goes to port 0; port 1's write waits
      issue(0, 1'b1);
      issue(1, 1'b0);
      drain(2000);

      allow_issue = 1; req_pct = 30;
      repeat (1500) cycle();
      req_pct = 100;
      repeat (800) cycle();
      allow_issue = 0;
      drain(2000);

      // Leave last = port 0, then abandon a port-1 read at beat 4
      issue(0, 1'b1);
      drain(2000);
      issue(1, 1'b1);
      n = 0;
      while (!(pstate[1] == 3 && prbeat[1] == 4) && n < 2000) begin
         cycle();
         n++;
      end
      chk("beat4_reached", prbeat[1], 4);
      apply_reset(1);
      cycle();

      // Tie after mid-burst reset must again favour port 0
      issue(0, 1'b0);
      issue(1, 1'b1);
      drain(2000);
      issue(1, 1'b1);
      drain(2000);

      for (int p = 0; p < 2; p++) begin
         chk("done_count", done[p], issued[p]);
         chk("resp_q_empty", resp_q[p].size(), 0);
         chk("wr_q_empty", wr_q[p].size(), 0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
